// File: rtl/ysyx_22040237_idu_if.sv
// IDU handshake bundle: IFU->IDU fetch channel and IDU->EXU operand channel.
// master = the IDU itself, slave = the IFU/EXU environment around it.
interface ysyx_22040237_idu_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [31:0] in_inst;

   logic        out_valid;
   logic        out_ready;
   logic [7:0]  inst_opcode;
   logic [63:0] op1;
   logic [63:0] op2;
   logic [63:0] op1_jump;
   logic [63:0] op2_jump;
   logic        is_jump;
   logic [4:0]  rd_addr;
   logic        rd_wen;
   logic        inst_ebreak;
   logic        invalid_inst;

   modport master (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, inst_opcode,
      output op1, op2, op1_jump, op2_jump,
      output is_jump, rd_addr, rd_wen,
      output inst_ebreak, invalid_inst
   );

   modport slave (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, inst_opcode,
      input  op1, op2, op1_jump, op2_jump,
      input  is_jump, rd_addr, rd_wen,
      input  inst_ebreak, invalid_inst
   );
endinterface

// File: rtl/ysyx_22040237_idu.sv
// Decode/issue stage: RV64I subset decode into a one-entry
// operand register toward the EXU; halts after EBREAK/invalid.
module ysyx_22040237_idu #(
   parameter logic [7:0] OPC_ADD = 8'h01,
   parameter logic [7:0] OPC_NOP = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   ysyx_22040237_idu_if.master bus,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   output logic        halted,
   output logic [31:0] issue_cnt
);

   logic [31:0] inst;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;

   assign inst     = bus.in_inst;
   assign opc      = inst[6:0];
   assign f3       = inst[14:12];
   assign f7       = inst[31:25];
   assign rd       = inst[11:7];
   assign rs1_addr = inst[19:15];
   assign rs2_addr = inst[24:20];

   logic [63:0] imm_i;
   logic [63:0] imm_u;
   logic [63:0] imm_j;

   assign imm_i = {{52{inst[31]}}, inst[31:20]};
   assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
   assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   // x0 always reads as zero whatever the regfile returns
   logic [63:0] src1;
   logic [63:0] src2;

   assign src1 = (rs1_addr == 5'd0) ? 64'd0 : rs1_data;
   assign src2 = (rs2_addr == 5'd0) ? 64'd0 : rs2_data;

   logic d_add, d_addi, d_lui, d_auipc;
   logic d_jal, d_jalr, d_ebreak;

   assign d_ebreak = (inst == 32'h0010_0073);
   assign d_add    = (opc == 7'b0110011) && (f3 == 3'b000)
                     && (f7 == 7'b0000000);
   assign d_addi   = (opc == 7'b0010011) && (f3 == 3'b000);
   assign d_lui    = (opc == 7'b0110111);
   assign d_auipc  = (opc == 7'b0010111);
   assign d_jal    = (opc == 7'b1101111);
   assign d_jalr   = (opc == 7'b1100111) && (f3 == 3'b000);

   logic [7:0]  n_opcode;
   logic [63:0] n_op1;
   logic [63:0] n_op2;
   logic [63:0] n_j1;
   logic [63:0] n_j2;
   logic        n_jump;
   logic        n_wr;
   logic        n_ebreak;
   logic        n_invalid;

   // operand bundle for the instruction currently offered by the IFU
   always_comb begin
      n_opcode  = OPC_ADD;
      n_op1     = 64'd0;
      n_op2     = 64'd0;
      n_j1      = 64'd0;
      n_j2      = 64'd0;
      n_jump    = 1'b0;
      n_wr      = 1'b0;
      n_ebreak  = 1'b0;
      n_invalid = 1'b0;
      unique case (1'b1)
         d_add: begin
            n_op1 = src1;
            n_op2 = src2;
            n_wr  = 1'b1;
         end
         d_addi: begin
            n_op1 = src1;
            n_op2 = imm_i;
            n_wr  = 1'b1;
         end
         d_lui: begin
            n_op2 = imm_u;
            n_wr  = 1'b1;
         end
         d_auipc: begin
            n_op1 = bus.in_pc;
            n_op2 = imm_u;
            n_wr  = 1'b1;
         end
         d_jal: begin
            n_op1  = bus.in_pc;
            n_op2  = 64'd4;
            n_j1   = bus.in_pc;
            n_j2   = imm_j;
            n_jump = 1'b1;
            n_wr   = 1'b1;
         end
         d_jalr: begin
            n_op1  = bus.in_pc;
            n_op2  = 64'd4;
            n_j1   = src1;
            n_j2   = imm_i;
            n_jump = 1'b1;
            n_wr   = 1'b1;
         end
         d_ebreak: begin
            n_ebreak = 1'b1;
         end
         default: begin
            n_opcode  = OPC_NOP;
            n_invalid = 1'b1;
         end
      endcase
   end

   logic v_q;
   logic fire_in;
   logic fire_out;

   assign bus.in_ready = !halted && (!v_q || bus.out_ready);
   assign fire_in      = bus.in_valid && bus.in_ready;
   assign fire_out     = v_q && bus.out_ready;

   // valid flag, halt latch and issue counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q       <= 1'b0;
         halted    <= 1'b0;
         issue_cnt <= 32'd0;
      end else begin
         if (fire_in)
            v_q <= 1'b1;
         else if (fire_out)
            v_q <= 1'b0;
         if (fire_in && (n_ebreak || n_invalid))
            halted <= 1'b1;
         if (fire_out)
            issue_cnt <= issue_cnt + 32'd1;
      end
   end

   logic [7:0]  q_opcode;
   logic [63:0] q_op1;
   logic [63:0] q_op2;
   logic [63:0] q_j1;
   logic [63:0] q_j2;
   logic        q_jump;
   logic [4:0]  q_rd;
   logic        q_wen;
   logic        q_ebreak;
   logic        q_invalid;

   // bundle register: loads only on capture, so it holds while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_opcode  <= 8'd0;
         q_op1     <= 64'd0;
         q_op2     <= 64'd0;
         q_j1      <= 64'd0;
         q_j2      <= 64'd0;
         q_jump    <= 1'b0;
         q_rd      <= 5'd0;
         q_wen     <= 1'b0;
         q_ebreak  <= 1'b0;
         q_invalid <= 1'b0;
      end else if (fire_in) begin
         q_opcode  <= n_opcode;
         q_op1     <= n_op1;
         q_op2     <= n_op2;
         q_j1      <= n_j1;
         q_j2      <= n_j2;
         q_jump    <= n_jump;
         q_rd      <= rd;
         q_wen     <= n_wr && (rd != 5'd0);
         q_ebreak  <= n_ebreak;
         q_invalid <= n_invalid;
      end
   end

   assign bus.out_valid    = v_q;
   assign bus.inst_opcode  = q_opcode;
   assign bus.op1          = q_op1;
   assign bus.op2          = q_op2;
   assign bus.op1_jump     = q_j1;
   assign bus.op2_jump     = q_j2;
   assign bus.is_jump      = q_jump;
   assign bus.rd_addr      = q_rd;
   assign bus.rd_wen       = q_wen;
   assign bus.inst_ebreak  = q_ebreak;
   assign bus.invalid_inst = q_invalid;

endmodule

// File: tb/tb_ysyx_22040237_idu.sv
// Bench for ysyx_22040237_idu: directed literals plus random
// traffic against a behavioural decode/handshake model.
module tb_ysyx_22040237_idu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic        halted;
   logic [31:0] issue_cnt;

   ysyx_22040237_idu_if bus ();

   ysyx_22040237_idu dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .halted    (halted),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  opc;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [63:0] j1;
      logic [63:0] j2;
      logic        jmp;
      logic [4:0]  rd;
      logic        wen;
      logic        ebreak;
      logic        invalid;
   } exp_t;

   int          nvec = 0;
   int          nerr = 0;
   logic        m_valid = 1'b0;
   logic        m_halted = 1'b0;
   logic [31:0] m_cnt = 32'd0;
   exp_t        m_b = '0;
   logic [63:0] regs [32];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // architectural meaning of each supported instruction
   function automatic exp_t ref_decode(input logic [31:0] w,
                                       input logic [63:0] pc,
                                       input logic [63:0] a,
                                       input logic [63:0] b);
      exp_t        r;
      logic [63:0] ii;
      logic [63:0] iu;
      logic [63:0] ij;
      logic [20:0] jr;
      logic        wr;
      r = '0;
      r.rd = w[11:7];
      r.opc = 8'h01;
      wr = 1'b0;
      ii = 64'(w[31:20]) - (w[31] ? 64'h1000 : 64'h0);
      iu = 64'({w[31:12], 12'h000}) - (w[31] ? 64'h1_0000_0000 : 64'h0);
      jr = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      ij = 64'(jr) - (w[31] ? 64'h20_0000 : 64'h0);
      if (w == 32'h0010_0073) begin
         r.ebreak = 1'b1;
      end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0
                   && w[31:25] == 7'd0) begin
         r.op1 = a; r.op2 = b; wr = 1'b1;
      end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
         r.op1 = a; r.op2 = ii; wr = 1'b1;
      end else if (w[6:0] == 7'h37) begin
         r.op2 = iu; wr = 1'b1;
      end else if (w[6:0] == 7'h17) begin
         r.op1 = pc; r.op2 = iu; wr = 1'b1;
      end else if (w[6:0] == 7'h6f) begin
         r.op1 = pc; r.op2 = 64'd4; r.j1 = pc; r.j2 = ij;
         r.jmp = 1'b1; wr = 1'b1;
      end else if (w[6:0] == 7'h67 && w[14:12] == 3'd0) begin
         r.op1 = pc; r.op2 = 64'd4; r.j1 = a; r.j2 = ii;
         r.jmp = 1'b1; wr = 1'b1;
      end else begin
         r.opc = 8'h00;
         r.invalid = 1'b1;
      end
      r.wen = wr && (r.rd != 5'd0);
      return r;
   endfunction

   task automatic check_regs();
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("halted", 64'(halted), 64'(m_halted));
      chk("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
      if (m_valid) begin
         chk("inst_opcode", 64'(bus.inst_opcode), 64'(m_b.opc));
         chk("op1", bus.op1, m_b.op1);
         chk("op2", bus.op2, m_b.op2);
         chk("op1_jump", bus.op1_jump, m_b.j1);
         chk("op2_jump", bus.op2_jump, m_b.j2);
         chk("is_jump", 64'(bus.is_jump), 64'(m_b.jmp));
         chk("rd_addr", 64'(bus.rd_addr), 64'(m_b.rd));
         chk("rd_wen", 64'(bus.rd_wen), 64'(m_b.wen));
         chk("inst_ebreak", 64'(bus.inst_ebreak), 64'(m_b.ebreak));
         chk("invalid_inst", 64'(bus.invalid_inst), 64'(m_b.invalid));
      end
   endtask

   // one clock: drive at negedge, model the edge, check at next negedge
   task automatic step(input logic v, input logic [63:0] pc,
                       input logic [31:0] w, input logic [63:0] d1,
                       input logic [63:0] d2, input logic ordy);
      exp_t nb;
      logic mrdy;
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_inst   = w;
      rs1_data      = d1;
      rs2_data      = d2;
      bus.out_ready = ordy;
      mrdy = !m_halted && (!m_valid || ordy);
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(mrdy));
      chk("rs1_addr", 64'(rs1_addr), 64'(w[19:15]));
      chk("rs2_addr", 64'(rs2_addr), 64'(w[24:20]));
      nb = ref_decode(w, pc, (w[19:15] == 5'd0) ? 64'd0 : d1,
                      (w[24:20] == 5'd0) ? 64'd0 : d2);
      @(posedge clk);
      if (m_valid && ordy)
         m_cnt = m_cnt + 32'd1;
      if (v && mrdy) begin
         m_b = nb;
         m_valid = 1'b1;
         if (nb.ebreak || nb.invalid)
            m_halted = 1'b1;
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check_regs();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_halted"}, 64'(halted), 64'd0);
      chk({tag, "_issue_cnt"}, 64'(issue_cnt), 64'd0);
      chk({tag, "_opcode"}, 64'(bus.inst_opcode), 64'd0);
      chk({tag, "_op1"}, bus.op1, 64'd0);
      chk({tag, "_op2"}, bus.op2, 64'd0);
      chk({tag, "_op1_jump"}, bus.op1_jump, 64'd0);
      chk({tag, "_op2_jump"}, bus.op2_jump, 64'd0);
      chk({tag, "_is_jump"}, 64'(bus.is_jump), 64'd0);
      chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
      chk({tag, "_rd_wen"}, 64'(bus.rd_wen), 64'd0);
      chk({tag, "_ebreak"}, 64'(bus.inst_ebreak), 64'd0);
      chk({tag, "_invalid"}, 64'(bus.invalid_inst), 64'd0);
   endtask

   // asynchronous reset in mid-cycle, entered from a negedge
   task automatic mid_reset();
      #2;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check_zero("rst");
      m_valid = 1'b0;
      m_halted = 1'b0;
      m_cnt = 32'd0;
      m_b = '0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   function automatic logic [31:0] rand_inst();
      int          k;
      logic [4:0]  rd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [11:0] i12;
      logic [19:0] i20;
      k   = int'($urandom_range(0, 99));
      rd  = 5'($urandom);
      r1  = 5'($urandom);
      r2  = 5'($urandom);
      i12 = 12'($urandom);
      i20 = 20'($urandom);
      if (k < 14) return {7'h00, r2, r1, 3'd0, rd, 7'h33};
      if (k < 34) return {i12, r1, 3'd0, rd, 7'h13};
      if (k < 46) return {i20, rd, 7'h37};
      if (k < 58) return {i20, rd, 7'h17};
      if (k < 70) return {i20, rd, 7'h6f};
      if (k < 82) return {i12, r1, 3'd0, rd, 7'h67};
      if (k == 82) return 32'h0010_0073;
      if (k == 83) return {7'h20, r2, r1, 3'd0, rd, 7'h33};
      if (k == 84) return {i12, r1, 3'(1 + $urandom_range(0, 6)), rd, 7'h13};
      if (k == 85) return $urandom;
      return {i12, r1, 3'd0, rd, 7'h13};
   endfunction

   initial begin
      logic [31:0] w;
      logic [63:0] pc;
      logic        v;
      logic        ordy;
      bus.in_valid  = 1'b0;
      bus.in_pc     = 64'd0;
      bus.in_inst   = 32'd0;
      bus.out_ready = 1'b0;
      rs1_data      = 64'd0;
      rs2_data      = 64'd0;

      @(negedge clk);
      check_zero("por");
      rst = 1'b1;
      #1;
      chk("por_in_ready", 64'(bus.in_ready), 64'd1);

      step(1'b1, 64'h8000_0000, 32'h0050_0093, 64'hAA, 64'hBB, 1'b1);
      chk("t1_op1", bus.op1, 64'd0);
      chk("t1_op2", bus.op2, 64'd5);
      chk("t1_rd", 64'(bus.rd_addr), 64'd1);
      chk("t1_wen", 64'(bus.rd_wen), 64'd1);
      chk("t1_jump", 64'(bus.is_jump), 64'd0);
      chk("t1_cnt", 64'(issue_cnt), 64'd0);

      bus.in_inst = 32'hFFF0_8113;
      #1;
      chk("t2_rs1_addr", 64'(rs1_addr), 64'd1);
      step(1'b1, 64'h8000_0004, 32'hFFF0_8113, 64'h10, 64'h0, 1'b1);
      chk("t2_op1", bus.op1, 64'h10);
      chk("t2_op2", bus.op2, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t2_rd", 64'(bus.rd_addr), 64'd2);
      chk("t2_cnt", 64'(issue_cnt), 64'd1);

      step(1'b1, 64'h8000_0010, 32'h0100_00EF, 64'h0, 64'h0, 1'b1);
      chk("t3_op1", bus.op1, 64'h8000_0010);
      chk("t3_op2", bus.op2, 64'd4);
      chk("t3_j1", bus.op1_jump, 64'h8000_0010);
      chk("t3_j2", bus.op2_jump, 64'd16);
      chk("t3_jump", 64'(bus.is_jump), 64'd1);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 64'h8000_0014, 32'h0030_0193, 64'h0, 64'h0, 1'b0);
         chk("hold_j1", bus.op1_jump, 64'h8000_0010);
         chk("hold_ready", 64'(bus.in_ready), 64'd0);
      end
      for (int i = 0; i < 4; i++)
         step(1'b1, 64'h8000_0014 + 64'(4 * i),
              {12'(i + 1), 5'd0, 3'd0, 5'd3, 7'h13}, 64'h0, 64'h0, 1'b1);
      chk("b2b_op2", bus.op2, 64'd4);
      chk("b2b_cnt", 64'(issue_cnt), 64'd6);
      step(1'b0, 64'h0, 32'h0, 64'h0, 64'h0, 1'b1);
      chk("drain_valid", 64'(bus.out_valid), 64'd0);
      chk("drain_cnt", 64'(issue_cnt), 64'd7);

      step(1'b1, 64'h8000_0030, 32'h0010_0073, 64'h1, 64'h2, 1'b0);
      chk("eb_flag", 64'(bus.inst_ebreak), 64'd1);
      chk("eb_halted", 64'(halted), 64'd1);
      chk("eb_wen", 64'(bus.rd_wen), 64'd0);
      chk("eb_opc", 64'(bus.inst_opcode), 64'h01);
      step(1'b1, 64'h8000_0034, 32'h0050_0093, 64'h0, 64'h0, 1'b0);
      step(1'b1, 64'h8000_0034, 32'h0050_0093, 64'h0, 64'h0, 1'b1);
      chk("eb_drained", 64'(bus.out_valid), 64'd0);
      step(1'b1, 64'h8000_0034, 32'h0050_0093, 64'h0, 64'h0, 1'b1);
      chk("eb_nocap", 64'(bus.out_valid), 64'd0);
      chk("eb_cnt", 64'(issue_cnt), 64'd8);
      mid_reset();

      step(1'b1, 64'h8000_0040, 32'hFFFF_FFFF, 64'h0, 64'h0, 1'b0);
      chk("inv_flag", 64'(bus.invalid_inst), 64'd1);
      chk("inv_opc", 64'(bus.inst_opcode), 64'h00);
      chk("inv_halted", 64'(halted), 64'd1);
      mid_reset();

      step(1'b1, 64'h8000_0050, 32'h0000_0013, 64'h5, 64'h6, 1'b0);
      chk("nop_wen", 64'(bus.rd_wen), 64'd0);
      chk("nop_inv", 64'(bus.invalid_inst), 64'd0);
      step(1'b0, 64'h0, 32'h0, 64'h0, 64'h0, 1'b0);
      chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      mid_reset();

      for (int ep = 0; ep < 30; ep++) begin
         for (int r = 0; r < 32; r++)
            regs[r] = {$urandom, $urandom};
         for (int c = 0; c < 50; c++) begin
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 70);
            w    = rand_inst();
            pc   = {32'd0, 32'h8000_0000 | {$urandom_range(0, 32'h3FFF), 2'b00}};
            step(v, pc, w, regs[w[19:15]], regs[w[24:20]], ordy);
         end
         mid_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ysyx_22040237_idu.md
Name: ysyx_22040237_idu

Overview:
Decode/issue stage feeding the execute unit: accepts fetched instructions from the IFU over a valid/ready handshake and decodes the RV64I subset ADD, ADDI, LUI, AUIPC, JAL, JALR and EBREAK. It reads register operands and places the operand bundle (opcode, op1/op2, jump operands, ebreak/invalid flags) into a one-entry output register with valid/ready toward the EXU. After issuing EBREAK or an invalid instruction it halts intake.

Parameters:
OPC_ADD, 8'h01, inst_opcode encoding for the add-class operation (must match EXU).
OPC_NOP, 8'h00, inst_opcode for invalid instructions.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  IFU instruction valid
in_ready  output  1  IDU can accept the instruction
in_pc  input  64  PC of the instruction
in_inst  input  32  instruction word
rs1_addr  output  5  regfile read address 1 (combinational from in_inst[19:15])
rs2_addr  output  5  regfile read address 2 (combinational from in_inst[24:20])
rs1_data  input  64  regfile read data 1, same cycle
rs2_data  input  64  regfile read data 2, same cycle
out_valid  output  1  bundle valid toward EXU
out_ready  input  1  EXU accepts bundle
inst_opcode  output  8  operation class
op1, op2  output  64 each  data operands
op1_jump, op2_jump  output  64 each  jump target operands
is_jump  output  1  jump target valid
rd_addr  output  5  destination register
rd_wen  output  1  destination write enable
inst_ebreak  output  1  instruction is EBREAK
invalid_inst  output  1  instruction not decodable
halted  output  1  intake stopped
issue_cnt  output  32  count of bundles accepted by EXU

Behaviour:
- Reset (rst=0, async): every registered output is 0, including out_valid, halted and issue_cnt; in_ready=1 once reset is released.
- in_ready = !halted && (!out_valid || out_ready). Capture occurs when in_valid && in_ready; the output register loads on the same edge, giving 1-cycle latency.
- Operand rules. x0 reads return 0 regardless of rs*_data. Immediates are sign-extended to 64 bits.
  - ADD: op1=rs1, op2=rs2.
  - ADDI: op1=rs1, op2=imm_i.
  - LUI: op1=0, op2=imm_u.
  - AUIPC: op1=pc, op2=imm_u.
  - JAL: op1=pc, op2=4, op1_jump=pc, op2_jump=imm_j, is_jump=1.
  - JALR: op1=pc, op2=4, op1_jump=rs1, op2_jump=imm_i, is_jump=1.
  - For non-jumps, op1_jump, op2_jump and is_jump are 0.
- inst_opcode=OPC_ADD for all valid instructions, including EBREAK. EBREAK has all operands 0, rd_wen=0 and inst_ebreak=1.
- Invalid encodings (any other opcode/funct3/funct7, or SYSTEM other than 0x00100073): inst_opcode=OPC_NOP, operands 0, rd_wen=0, invalid_inst=1.
- rd_addr=inst[11:7]. rd_wen=1 only for valid writing instructions with rd!=0.
- Hold: while out_valid && !out_ready, every output stays bit-stable and in_ready=0.
- Simultaneous drain and fill: out_valid stays 1 and the register is replaced with no bubble.
- Drain with no fill: out_valid falls to 0 on the next edge.
- issue_cnt increments on each out_valid && out_ready edge and wraps modulo 2^32.
- halted sets on the edge capturing an EBREAK or invalid instruction and remains set until reset. The already-captured bundle still drains normally; no further instructions are accepted.
- Reset mid-operation discards any held bundle immediately.

Test Plan:
- pc=0x80000000, inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, op1=0, op2=5, rd_addr=1, rd_wen=1, is_jump=0, issue_cnt 0->1.
- inst=0xFFF08113 (addi x2,x1,-1) with rs1_data=0x10 -> rs1_addr=1, op1=0x10, op2=0xFFFFFFFFFFFFFFFF, rd_addr=2.
- pc=0x80000010, inst=0x010000EF (jal x1,16) -> op1=0x80000010, op2=4, op1_jump=0x80000010, op2_jump=16, is_jump=1.
- out_ready=0 for 3 cycles with a bundle held and in_valid=1 -> in_ready=0 and outputs stable; on release, back-to-back instructions issue one per cycle.
- inst=0x00100073 -> inst_ebreak=1, halted=1, in_ready=0 forever after; bundle drains; a following addi is never captured.
- inst=0xFFFFFFFF -> invalid_inst=1, inst_opcode=0x00, halted=1. Separately, inst=0x00000013 -> rd_wen=0. Asserting rst while out_valid=1 -> all outputs 0 at once.
